// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: next-PC select encodings, NOP word,
// default reset vector and instruction field positions.
package mips_pkg;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'b00,
        NPC_BR  = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_sel_e;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int TARGET_MSB = 25;
    localparam int TARGET_LSB = 0;

    // Branch displacement in bytes: sign-extended word offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Signals between the fetch stage and its neighbours: hazard unit control,
// ID-stage redirect inputs, instruction memory and the IF/ID outputs.
interface if_stage_if
    import mips_pkg::*;
#(
    parameter int IMEM_AW = 10
);
    logic               stall;
    logic               flush;
    npc_sel_e           npc_sel;
    logic               br_taken;
    logic [31:0]        rs_val_d;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic [31:0]        instr_d;
    logic [31:0]        pc_d;
    logic [31:0]        pc8_d;
    logic               valid_d;

    // Environment side: hazard unit, ID stage and instruction memory.
    modport master (
        output stall,
        output flush,
        output npc_sel,
        output br_taken,
        output rs_val_d,
        output imem_rdata,
        input  imem_addr,
        input  instr_d,
        input  pc_d,
        input  pc8_d,
        input  valid_d
    );

    // Fetch stage side.
    modport slave (
        input  stall,
        input  flush,
        input  npc_sel,
        input  br_taken,
        input  rs_val_d,
        input  imem_rdata,
        output imem_addr,
        output instr_d,
        output pc_d,
        output pc8_d,
        output valid_d
    );

endinterface

// File: rtl/if_stage_npc_unit.sv
// Combinational next-PC selection. Branch and jump targets are built from
// the instruction currently in ID, so the delay slot is fetched first.
module npc_unit
    import mips_pkg::*;
(
    input  logic [31:0]                   pc_f,
    input  logic [31:0]                   pc_d,
    input  logic [TARGET_MSB:TARGET_LSB]  instr_idx,
    input  npc_sel_e                      npc_sel,
    input  logic                          br_taken,
    input  logic [31:0]                   rs_val_d,
    output logic [31:0]                   npc
);
    logic [31:0] seq_pc;
    logic [31:0] br_pc;
    logic [31:0] j_pc;

    assign seq_pc = pc_f + 32'd4;
    assign br_pc  = pc_d + 32'd4 + branch_offset(instr_idx[IMM_MSB:IMM_LSB]);
    // Region bits come from the delay-slot PC, which is pc_d + 4; for a
    // jump in the last word of a region that differs from pc_d itself.
    assign j_pc   = {br_pc_region(pc_d), instr_idx, 2'b00};

    function automatic logic [3:0] br_pc_region(input logic [31:0] pc);
        logic [31:0] slot_pc;
        slot_pc = pc + 32'd4;
        return slot_pc[31:28];
    endfunction

    always_comb begin
        npc = seq_pc;
        case (npc_sel)
            NPC_SEQ: npc = seq_pc;
            NPC_BR:  npc = br_taken ? br_pc : seq_pc;
            NPC_J:   npc = j_pc;
            NPC_JR:  npc = rs_val_d;
            default: npc = seq_pc;
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC select and IF/ID register.
// Stall holds PC and IF/ID; flush forces a NOP bubble into IF/ID.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          IMEM_AW  = 10
) (
    input  logic       clk,
    input  logic       reset,
    if_stage_if.slave  bus
);
    logic [31:0] pc_f_reg,    pc_f_next;
    logic [31:0] instr_d_reg, instr_d_next;
    logic [31:0] pc_d_reg,    pc_d_next;
    logic [31:0] pc8_d_reg,   pc8_d_next;
    logic        valid_d_reg, valid_d_next;
    logic [31:0] npc;

    npc_unit u_npc (
        .pc_f      (pc_f_reg),
        .pc_d      (pc_d_reg),
        .instr_idx (instr_d_reg[TARGET_MSB:TARGET_LSB]),
        .npc_sel   (bus.npc_sel),
        .br_taken  (bus.br_taken),
        .rs_val_d  (bus.rs_val_d),
        .npc       (npc)
    );

    always_comb begin
        pc_f_next    = pc_f_reg;
        instr_d_next = instr_d_reg;
        pc_d_next    = pc_d_reg;
        pc8_d_next   = pc8_d_reg;
        valid_d_next = valid_d_reg;

        if (!bus.stall) begin
            pc_f_next = npc;
        end

        // Flush wins over the stall hold of IF/ID; the PC still obeys stall.
        if (bus.flush) begin
            instr_d_next = NOP;
            pc_d_next    = pc_f_reg;
            pc8_d_next   = pc_f_reg + 32'd8;
            valid_d_next = 1'b0;
        end else if (!bus.stall) begin
            instr_d_next = bus.imem_rdata;
            pc_d_next    = pc_f_reg;
            pc8_d_next   = pc_f_reg + 32'd8;
            valid_d_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f_reg    <= RESET_PC;
            instr_d_reg <= NOP;
            pc_d_reg    <= RESET_PC;
            pc8_d_reg   <= RESET_PC + 32'd8;
            valid_d_reg <= 1'b0;
        end else begin
            pc_f_reg    <= pc_f_next;
            instr_d_reg <= instr_d_next;
            pc_d_reg    <= pc_d_next;
            pc8_d_reg   <= pc8_d_next;
            valid_d_reg <= valid_d_next;
        end
    end

    // Word offset from the memory base, wrapping modulo the memory depth.
    assign bus.imem_addr = IMEM_AW'((pc_f_reg - RESET_PC) >> 2);
    assign bus.instr_d   = instr_d_reg;
    assign bus.pc_d      = pc_d_reg;
    assign bus.pc8_d     = pc8_d_reg;
    assign bus.valid_d   = valid_d_reg;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: table of per-cycle vectors plus a few
// hand-written reset sequences, checked through an expected-output queue.
module tb_if_stage;
    import mips_pkg::*;

    localparam int AW = 10;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        npc_sel_e    sel;
        logic        br;
        logic [31:0] rs;
        logic [AW-1:0] exp_addr;
        logic [31:0] exp_pc_d;
        logic [31:0] exp_instr;
        logic        exp_valid;
    } vec_t;

    logic clk;
    logic reset;
    logic [31:0] mem [0:(1<<AW)-1];

    vec_t vecs[$];
    vec_t exp_q[$];
    int   tests;
    int   failed;
    int   txn;

    if_stage_if #(.IMEM_AW(AW)) bus ();

    if_stage #(.RESET_PC(32'h0000_3000), .IMEM_AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    assign bus.imem_rdata = mem[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s (txn %0d): got %h expected %h", name, txn, act, exp);
        end
    endtask

    task automatic add_vec(input logic r, input logic st, input logic fl, input npc_sel_e sel,
                           input logic br, input logic [31:0] rs, input int addr,
                           input logic [31:0] pcd, input logic [31:0] ins, input logic vld);
        vec_t v;
        v.rst = r; v.stall = st; v.flush = fl; v.sel = sel; v.br = br; v.rs = rs;
        v.exp_addr = AW'(addr); v.exp_pc_d = pcd; v.exp_instr = ins; v.exp_valid = vld;
        vecs.push_back(v);
    endtask

    task automatic step(input vec_t v);
        vec_t e;
        @(negedge clk);
        reset        = v.rst;
        bus.stall    = v.stall;
        bus.flush    = v.flush;
        bus.npc_sel  = v.sel;
        bus.br_taken = v.br;
        bus.rs_val_d = v.rs;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL scoreboard: got empty queue expected entry");
        end else begin
            e = exp_q.pop_front();
            chk("imem_addr", 32'(bus.imem_addr), 32'(e.exp_addr));
            chk("pc_d",      bus.pc_d,    e.exp_pc_d);
            chk("pc8_d",     bus.pc8_d,   e.exp_pc_d + 32'd8);
            chk("instr_d",   bus.instr_d, e.exp_instr);
            chk("valid_d",   32'(bus.valid_d), 32'(e.exp_valid));
            $display("[TB] txn %0d: addr=%0d pc_d=%h pc8_d=%h instr_d=%h valid_d=%b",
                     txn, bus.imem_addr, bus.pc_d, bus.pc8_d, bus.instr_d, bus.valid_d);
        end
        txn++;
    endtask

    task automatic hand(input logic r, input logic st, input npc_sel_e sel, input logic br,
                        input int addr, input logic [31:0] pcd, input logic [31:0] ins,
                        input logic vld);
        vec_t v;
        v.rst = r; v.stall = st; v.flush = 1'b0; v.sel = sel; v.br = br; v.rs = 32'h0;
        v.exp_addr = AW'(addr); v.exp_pc_d = pcd; v.exp_instr = ins; v.exp_valid = vld;
        step(v);
    endtask

    initial begin
        tests = 0; failed = 0; txn = 0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h2400_0000 | i;
        mem[4]  = 32'h1000_0003;   // beq, imm 3 (taken)
        mem[10] = 32'h1000_0003;   // beq, imm 3 (not taken)
        mem[14] = 32'h1000_0003;   // beq, imm 3 (stalled, then taken)
        mem[20] = 32'h0800_0C10;   // j 0xC10 -> 0x3040

        reset = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0;
        bus.npc_sel = NPC_SEQ; bus.br_taken = 1'b0; bus.rs_val_d = 32'h0;

        add_vec(1,0,0,NPC_SEQ,0,0,             0,   32'h3000, NOP,      0);
        add_vec(0,0,0,NPC_SEQ,0,0,             1,   32'h3000, mem[0],   1);
        add_vec(0,0,0,NPC_SEQ,0,0,             2,   32'h3004, mem[1],   1);
        add_vec(0,1,0,NPC_SEQ,0,0,             2,   32'h3004, mem[1],   1);
        add_vec(0,1,0,NPC_SEQ,0,0,             2,   32'h3004, mem[1],   1);
        add_vec(0,0,0,NPC_SEQ,0,0,             3,   32'h3008, mem[2],   1);
        add_vec(0,0,0,NPC_SEQ,0,0,             4,   32'h300C, mem[3],   1);
        add_vec(0,0,0,NPC_SEQ,0,0,             5,   32'h3010, mem[4],   1);
        add_vec(0,0,0,NPC_BR, 1,0,             8,   32'h3014, mem[5],   1);
        add_vec(0,0,0,NPC_SEQ,0,0,             9,   32'h3020, mem[8],   1);
        add_vec(0,0,0,NPC_SEQ,0,0,             10,  32'h3024, mem[9],   1);
        add_vec(0,0,0,NPC_SEQ,0,0,             11,  32'h3028, mem[10],  1);
        add_vec(0,0,0,NPC_BR, 0,0,             12,  32'h302C, mem[11],  1);
        add_vec(0,0,0,NPC_SEQ,0,0,             13,  32'h3030, mem[12],  1);
        add_vec(0,0,0,NPC_SEQ,0,0,             14,  32'h3034, mem[13],  1);
        add_vec(0,0,0,NPC_SEQ,0,0,             15,  32'h3038, mem[14],  1);
        add_vec(0,1,0,NPC_BR, 1,0,             15,  32'h3038, mem[14],  1);
        add_vec(0,0,0,NPC_BR, 1,0,             18,  32'h303C, mem[15],  1);
        add_vec(0,0,0,NPC_SEQ,0,0,             19,  32'h3048, mem[18],  1);
        add_vec(0,0,0,NPC_SEQ,0,0,             20,  32'h304C, mem[19],  1);
        add_vec(0,0,0,NPC_SEQ,0,0,             21,  32'h3050, mem[20],  1);
        add_vec(0,0,0,NPC_J,  0,0,             16,  32'h3054, mem[21],  1);
        add_vec(0,0,0,NPC_SEQ,0,0,             17,  32'h3040, mem[16],  1);
        add_vec(0,0,0,NPC_JR, 0,32'h3100,      64,  32'h3044, mem[17],  1);
        add_vec(0,0,0,NPC_SEQ,0,0,             65,  32'h3100, mem[64],  1);
        add_vec(0,0,1,NPC_SEQ,0,0,             66,  32'h3104, NOP,      0);
        add_vec(0,0,0,NPC_SEQ,0,0,             67,  32'h3108, mem[66],  1);
        add_vec(0,1,1,NPC_SEQ,0,0,             67,  32'h310C, NOP,      0);
        add_vec(0,0,0,NPC_SEQ,0,0,             68,  32'h310C, mem[67],  1);
        add_vec(0,0,0,NPC_JR, 0,32'hFFFF_FFFC, 1023,32'h3110, mem[68],  1);
        add_vec(0,0,0,NPC_SEQ,0,0,             0,   32'hFFFF_FFFC, mem[1023], 1);
        add_vec(0,0,0,NPC_SEQ,0,0,             1,   32'h0000_0000, mem[0],    1);

        foreach (vecs[i]) step(vecs[i]);

        // Reset asserted while stalled: reset values, then normal fetch.
        hand(0,1,NPC_SEQ,0, 1, 32'h0000_0000, mem[0], 1);
        hand(1,1,NPC_SEQ,0, 0, 32'h3000, NOP,    0);
        hand(0,0,NPC_SEQ,0, 1, 32'h3000, mem[0], 1);

        // Reset asserted with a taken branch in ID: the redirect is dropped.
        hand(0,0,NPC_SEQ,0, 2, 32'h3004, mem[1], 1);
        hand(0,0,NPC_SEQ,0, 3, 32'h3008, mem[2], 1);
        hand(0,0,NPC_SEQ,0, 4, 32'h300C, mem[3], 1);
        hand(0,0,NPC_SEQ,0, 5, 32'h3010, mem[4], 1);
        hand(1,0,NPC_BR, 1, 0, 32'h3000, NOP,    0);
        hand(0,0,NPC_SEQ,0, 1, 32'h3000, mem[0], 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
